// File: rtl/serial_transmitter_fifo.sv
`timescale 1ns / 1ps
// Asynchronous-style serial transmitter with a small transmit FIFO.
// Frames are LSB first with optional parity and 1 or 2 stop bits, sent back to back.
module serial_transmitter_fifo #(
  parameter int unsigned ClockFrequency = 16000000,
  parameter int unsigned BaudRate       = 115200,
  parameter int unsigned DataBits       = 8,
  parameter int unsigned Parity         = 0,
  parameter int unsigned StopBits       = 1,
  parameter int unsigned FifoDepth      = 4
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic [DataBits-1:0] iData,
  input  logic                iSend,
  output logic                oReady,
  output logic                oBusy,
  output logic                oTXD
);

  localparam int unsigned TicksPerBit = ClockFrequency / BaudRate;
  localparam int unsigned PtrW        = $clog2(FifoDepth);
  localparam int unsigned CntW        = PtrW + 1;
  localparam int unsigned TickW       = $clog2(TicksPerBit);
  localparam int unsigned BitW        = $clog2(DataBits);

  if ((DataBits < 5) || (DataBits > 9)) begin : g_bad_data_bits
    $error("DataBits must be in 5..9");
  end
  if (Parity > 2) begin : g_bad_parity
    $error("Parity must be 0, 1 or 2");
  end
  if ((StopBits < 1) || (StopBits > 2)) begin : g_bad_stop_bits
    $error("StopBits must be 1 or 2");
  end
  if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : g_bad_fifo_depth
    $error("FifoDepth must be a power of two, at least 2");
  end
  if (TicksPerBit < 3) begin : g_bad_ticks
    $error("ClockFrequency / BaudRate must be at least 3");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

  logic [DataBits-1:0] r_mem [FifoDepth];
  logic [PtrW-1:0]     r_wr_ptr   = '0;
  logic [PtrW-1:0]     r_rd_ptr   = '0;
  logic [CntW-1:0]     r_count    = '0;
  logic                r_ready    = 1'b0;

  state_t              r_state    = StIdle;
  logic [TickW-1:0]    r_tick     = '0;
  logic [BitW-1:0]     r_bit_idx  = '0;
  logic [DataBits-1:0] r_shift    = '0;
  logic                r_parity   = 1'b0;
  logic                r_txd      = 1'b1;
  logic                r_busy     = 1'b0;

  logic                w_push;
  logic                w_pop;
  logic                w_not_empty;
  logic                w_bit_end;
  logic                w_last_stop;
  logic [CntW-1:0]     w_count_next;
  logic [DataBits-1:0] w_head;
  logic                w_head_parity;

  assign w_push        = iSend & r_ready;
  assign w_not_empty   = (r_count != '0);
  assign w_bit_end     = (r_tick == TickW'(TicksPerBit - 1));
  assign w_last_stop   = (r_state == StStop) && w_bit_end && (r_bit_idx == BitW'(StopBits - 1));
  assign w_pop         = w_not_empty && ((r_state == StIdle) || w_last_stop);
  assign w_count_next  = r_count + CntW'(w_push) - CntW'(w_pop);
  assign w_head        = r_mem[r_rd_ptr];
  // Odd parity is the inverse of the data XOR.
  assign w_head_parity = (^w_head) ^ (Parity == 1);

  always_ff @(posedge iClock) begin
    if (w_push && !iReset) begin
      r_mem[r_wr_ptr] <= iData;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      r_ready <= (w_count_next != CntW'(FifoDepth));
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state   <= StIdle;
      r_tick    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= (r_state != StIdle) || w_not_empty;

      case (r_state)
        StStart:  r_txd <= 1'b0;
        StData:   r_txd <= r_shift[0];
        StParity: r_txd <= r_parity;
        default:  r_txd <= 1'b1;
      endcase

      if (r_state == StIdle || w_bit_end) begin
        r_tick <= '0;
      end else begin
        r_tick <= r_tick + 1'b1;
      end

      case (r_state)
        StIdle: begin
          if (w_not_empty) begin
            r_state   <= StStart;
            r_shift   <= w_head;
            r_parity  <= w_head_parity;
            r_bit_idx <= '0;
          end
        end
        StStart: begin
          if (w_bit_end) begin
            r_state   <= StData;
            r_bit_idx <= '0;
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == BitW'(DataBits - 1)) begin
              r_bit_idx <= '0;
              r_state   <= (Parity != 0) ? StParity : StStop;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        StParity: begin
          if (w_bit_end) begin
            r_state   <= StStop;
            r_bit_idx <= '0;
          end
        end
        StStop: begin
          if (w_bit_end) begin
            if (r_bit_idx == BitW'(StopBits - 1)) begin
              r_bit_idx <= '0;
              if (w_not_empty) begin
                r_state  <= StStart;
                r_shift  <= w_head;
                r_parity <= w_head_parity;
              end else begin
                r_state <= StIdle;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign oReady = r_ready;
  assign oBusy  = r_busy;
  assign oTXD   = r_txd;

endmodule

// File: tb/tb_serial_transmitter_fifo.sv
`timescale 1ns / 1ps
// Directed bench for serial_transmitter_fifo: 8N1, 7E2 and 8O1 instances at 4 clocks per bit.
module tb_serial_transmitter_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_a = '0;
  logic [6:0] data_b = '0;
  logic [7:0] data_c = '0;
  logic       send_a = 1'b0;
  logic       send_b = 1'b0;
  logic       send_c = 1'b0;
  logic       ready_a, ready_b, ready_c;
  logic       busy_a, busy_b, busy_c;
  logic       txd_a, txd_b, txd_c;
  int         sel = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  serial_transmitter_fifo #(
    .ClockFrequency(1000000), .BaudRate(250000), .DataBits(8), .Parity(0), .StopBits(1),
    .FifoDepth(4)
  ) u_8n1 (
    .iClock(clk), .iReset(rst), .iData(data_a), .iSend(send_a),
    .oReady(ready_a), .oBusy(busy_a), .oTXD(txd_a)
  );

  serial_transmitter_fifo #(
    .ClockFrequency(1000000), .BaudRate(250000), .DataBits(7), .Parity(2), .StopBits(2),
    .FifoDepth(4)
  ) u_7e2 (
    .iClock(clk), .iReset(rst), .iData(data_b), .iSend(send_b),
    .oReady(ready_b), .oBusy(busy_b), .oTXD(txd_b)
  );

  serial_transmitter_fifo #(
    .ClockFrequency(1000000), .BaudRate(250000), .DataBits(8), .Parity(1), .StopBits(1),
    .FifoDepth(4)
  ) u_8o1 (
    .iClock(clk), .iReset(rst), .iData(data_c), .iSend(send_c),
    .oReady(ready_c), .oBusy(busy_c), .oTXD(txd_c)
  );

  logic w_txd, w_busy, w_ready;
  assign w_txd   = (sel == 0) ? txd_a   : (sel == 1) ? txd_b   : txd_c;
  assign w_busy  = (sel == 0) ? busy_a  : (sel == 1) ? busy_b  : busy_c;
  assign w_ready = (sel == 0) ? ready_a : (sel == 1) ? ready_b : ready_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level of bit i of a frame carrying w.
  function automatic logic frame_bit(input logic [8:0] w, input int db, input int par, input int i);
    logic p;
    if (i == 0) return 1'b0;
    if (i <= db) return w[i-1];
    if (par != 0 && i == db + 1) begin
      p = 1'b0;
      for (int j = 0; j < db; j++) p = p ^ w[j];
      return (par == 1) ? ~p : p;
    end
    return 1'b1;
  endfunction

  task automatic drive(input int s, input logic v, input logic [8:0] word);
    send_a = 1'b0;
    send_b = 1'b0;
    send_c = 1'b0;
    if (s == 0) begin send_a = v; data_a = word[7:0]; end
    if (s == 1) begin send_b = v; data_b = word[6:0]; end
    if (s == 2) begin send_c = v; data_c = word[7:0]; end
  endtask

  task automatic frame_test(input int s, input logic [8:0] word, input int db, input int par,
                            input int sb, input string name);
    int nbits;
    nbits = 1 + db + ((par != 0) ? 1 : 0) + sb;
    @(negedge clk);
    sel = s;
    drive(s, 1'b1, word);
    check({name, "_ready"}, w_ready, 1);
    @(posedge clk);
    @(negedge clk);
    drive(s, 1'b0, word);
    check({name, "_pre_start0"}, w_txd, 1);
    @(posedge clk);
    @(negedge clk);
    check({name, "_pre_start1"}, w_txd, 1);
    for (int b = 0; b < nbits; b++) begin
      for (int t = 0; t < 4; t++) begin
        @(posedge clk);
        @(negedge clk);
        if (t == 1 || (b == 0 && t == 0)) begin
          check($sformatf("%s_bit%0d_t%0d", name, b, t), w_txd, frame_bit(word, db, par, b));
        end
      end
    end
    check({name, "_busy_last"}, w_busy, 1);
    @(posedge clk);
    @(negedge clk);
    check({name, "_busy_fall"}, w_busy, 0);
    check({name, "_idle_txd"}, w_txd, 1);
  endtask

  logic [7:0] words [8];
  int         accepted;
  int         jj;
  int         bi;
  logic       seen_activity;

  initial begin
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    // Reset state and oReady rising one edge after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_txd", txd_a, 1);
    check("rst_ready", ready_a, 0);
    check("rst_busy", busy_a, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_rise", ready_a, 1);
    check("ready_rise_7e2", ready_b, 1);
    check("busy_idle", busy_a, 0);

    frame_test(0, 9'h0A5, 8, 0, 1, "8n1_a5");
    frame_test(1, 9'h041, 7, 2, 2, "7e2_41");
    frame_test(2, 9'h0FF, 8, 1, 1, "8o1_ff");
    frame_test(2, 9'h000, 8, 1, 1, "8o1_00");
    frame_test(2, 9'h001, 8, 1, 1, "8o1_01");

    // Burst of 8 words with iSend held high: 5 accepted, 5 gap-free frames.
    sel = 0;
    accepted = 0;
    for (int k = 0; k <= 205; k++) begin
      @(negedge clk);
      jj = k - 1;
      if (jj >= 2 && ((jj - 2) % 4) == 1 && ((jj - 2) / 4) < 50) begin
        bi = (jj - 2) / 4;
        check($sformatf("burst_bit%0d", bi), txd_a,
              frame_bit({1'b0, words[bi/10]}, 8, 0, bi % 10));
      end
      if (k == 5) check("burst_ready_full", ready_a, 0);
      if (k < 8) begin
        drive(0, 1'b1, {1'b0, words[k]});
        if (ready_a) accepted++;
      end else begin
        drive(0, 1'b0, 9'h000);
      end
    end
    check("burst_accepted", accepted, 5);
    check("burst_busy_end", busy_a, 0);

    // Push on the same edge as the end-of-frame pop with 3 words queued.
    for (int k = 0; k <= 42; k++) begin
      @(negedge clk);
      if (k == 41) begin
        check("pp_count_before", u_8n1.r_count, 3);
        check("pp_ready_before", ready_a, 1);
      end
      if (k == 42) begin
        check("pp_count_after", u_8n1.r_count, 3);
        check("pp_ready_after", ready_a, 1);
      end
      if (k <= 3 || k == 41) drive(0, 1'b1, 9'h0C0 + 9'(k));
      else drive(0, 1'b0, 9'h000);
    end

    // Clear the queue, then reset during data bit 3 with 2 words queued.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    seen_activity = 1'b0;
    for (int k = 0; k <= 150; k++) begin
      @(negedge clk);
      if (k == 19) check("mr_bit3_low", txd_a, 0);
      if (k == 20) begin
        check("mr_txd", txd_a, 1);
        check("mr_busy", busy_a, 0);
        check("mr_ready_low", ready_a, 0);
        rst = 1'b0;
      end
      if (k == 21) check("mr_ready_rise", ready_a, 1);
      if (k >= 21 && (txd_a !== 1'b1 || busy_a !== 1'b0)) seen_activity = 1'b1;
      if (k == 19) rst = 1'b1;
      if (k <= 2) drive(0, 1'b1, 9'h0F7 - 9'(k));
      else drive(0, 1'b0, 9'h000);
    end
    check("mr_no_frames", seen_activity, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
